segment_sequencer: RTL and testbench

SEGMENT_SEQUENCER -- requirements
Module: segment_sequencer

---
 rtl/segment_sequencer_pkg.sv | 14 +
 rtl/segment_sequencer_if.sv | 29 ++
 rtl/segment_sequencer_button_debouncer.sv | 97 +++++++++
 rtl/segment_sequencer.sv | 90 +++++++++
 tb/tb_segment_sequencer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/segment_sequencer_pkg.sv
// Shared constants and debounce state encoding for the segment sequencer.
package segment_sequencer_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEFAULT_AUTO_PERIOD     = 8;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PRESS_WAIT,
    DB_PRESSED,
    DB_RELEASE_WAIT
  } db_state_e;

endpackage

// File: rtl/segment_sequencer_if.sv
// Button inputs and segment-driver pulse outputs of the segment sequencer.
interface segment_sequencer_if;

  logic       btn_next;
  logic       btn_mode;
  logic       auto_en;
  logic       next_segment_re;
  logic       change_mode_re;
  logic [7:0] step_count;

  modport master (
    input  btn_next,
    input  btn_mode,
    input  auto_en,
    output next_segment_re,
    output change_mode_re,
    output step_count
  );

  modport slave (
    output btn_next,
    output btn_mode,
    output auto_en,
    input  next_segment_re,
    input  change_mode_re,
    input  step_count
  );

endinterface

// File: rtl/segment_sequencer_button_debouncer.sv
// Two-flop synchronizer plus debounce FSM; press_req is high for the single
// cycle in which a press has been stable for DEBOUNCE_CYCLES samples.
module button_debouncer
  import segment_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic async_reset,
  input  logic btn_raw,
  output logic press_req
);

  // Counter holds stable samples already seen; the sample that reaches
  // DEBOUNCE_CYCLES is the one that takes the transition.
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic      meta_q;
  logic      sync_q;
  db_state_e state_q;
  db_state_e state_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      state_q <= DB_IDLE;
      cnt_q   <= '0;
    end else begin
      meta_q  <= btn_raw;
      sync_q  <= meta_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_req = 1'b0;
    unique case (state_q)
      DB_IDLE: begin
        if (sync_q) begin
          if (CNT_LAST == 8'd0) begin
            state_d   = DB_PRESSED;
            press_req = 1'b1;
            cnt_d     = '0;
          end else begin
            state_d = DB_PRESS_WAIT;
            cnt_d   = 8'd1;
          end
        end
      end
      DB_PRESS_WAIT: begin
        if (!sync_q) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = DB_PRESSED;
          press_req = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DB_PRESSED: begin
        if (!sync_q) begin
          if (CNT_LAST == 8'd0) begin
            state_d = DB_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = DB_RELEASE_WAIT;
            cnt_d   = 8'd1;
          end
        end
      end
      DB_RELEASE_WAIT: begin
        if (sync_q) begin
          state_d = DB_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = DB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/segment_sequencer.sv
// Debounced buttons and an auto-advance timer merged into registered
// next/mode pulses for the segment driver, with mode taking priority.
module segment_sequencer
  import segment_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned AUTO_PERIOD     = DEFAULT_AUTO_PERIOD
) (
  input  logic                   clk,
  input  logic                   async_reset,
  segment_sequencer_if.master    bus
);

  localparam logic [15:0] TIMER_LAST = 16'(AUTO_PERIOD - 1);

  logic        next_btn_req;
  logic        mode_req;
  logic        auto_req;
  logic        next_req;
  logic [15:0] timer_q;
  logic [15:0] timer_d;
  logic        pending_q;
  logic        pending_d;
  logic        next_pulse_q;
  logic        next_pulse_d;
  logic        mode_pulse_q;
  logic        mode_pulse_d;
  logic [7:0]  step_q;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
    .clk         (clk),
    .async_reset (async_reset),
    .btn_raw     (bus.btn_next),
    .press_req   (next_btn_req)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk         (clk),
    .async_reset (async_reset),
    .btn_raw     (bus.btn_mode),
    .press_req   (mode_req)
  );

  always_comb begin
    auto_req = 1'b0;
    timer_d  = timer_q + 16'd1;
    // A manual advance restarts the period and swallows a coincident tick.
    if (!bus.auto_en || next_btn_req) begin
      timer_d = '0;
    end else if (timer_q == TIMER_LAST) begin
      timer_d  = '0;
      auto_req = 1'b1;
    end
    next_req = next_btn_req | auto_req;

    next_pulse_d = 1'b0;
    mode_pulse_d = 1'b0;
    pending_d    = pending_q;
    if (mode_req) begin
      mode_pulse_d = 1'b1;
      pending_d    = pending_q | next_req;
    end else begin
      next_pulse_d = next_req | pending_q;
      pending_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      timer_q      <= '0;
      pending_q    <= 1'b0;
      next_pulse_q <= 1'b0;
      mode_pulse_q <= 1'b0;
      step_q       <= '0;
    end else begin
      timer_q      <= timer_d;
      pending_q    <= pending_d;
      next_pulse_q <= next_pulse_d;
      mode_pulse_q <= mode_pulse_d;
      if (next_pulse_q) begin
        step_q <= step_q + 8'd1;
      end
    end
  end

  assign bus.next_segment_re = next_pulse_q;
  assign bus.change_mode_re  = mode_pulse_q;
  assign bus.step_count      = step_q;

endmodule

// File: tb/tb_segment_sequencer.sv
// Scoreboard bench: each scenario queues the cycles in which pulses are due,
// then checks {next, mode, step_count} every cycle against that schedule.
module tb_segment_sequencer;

  localparam int unsigned DB = 4;
  localparam int unsigned AP = 8;

  logic clk = 1'b0;
  logic async_reset = 1'b1;

  segment_sequencer_if bus ();

  segment_sequencer #(.DEBOUNCE_CYCLES(DB), .AUTO_PERIOD(AP)) dut (
    .clk         (clk),
    .async_reset (async_reset),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc;
  int nq[$];
  int mq[$];
  logic en, em;
  logic [7:0] es;

  // Cycle n starts at the n-th rising edge after reset release.
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic apply_reset();
    async_reset  = 1'b1;
    bus.btn_next = 1'b0;
    bus.btn_mode = 1'b0;
    bus.auto_en  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    async_reset = 1'b0;
    cyc = -1;
    es  = '0;
    nq.delete();
    mq.delete();
  endtask

  task automatic pop_expect();
    en = (nq.size() > 0 && nq[0] == cyc);
    if (en) void'(nq.pop_front());
    em = (mq.size() > 0 && mq[0] == cyc);
    if (em) void'(mq.pop_front());
  endtask

  task automatic test_reset();
    async_reset  = 1'b1;
    bus.btn_next = 1'b1;
    bus.btn_mode = 1'b1;
    bus.auto_en  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({bus.next_segment_re, bus.change_mode_re, bus.step_count} !== 10'd0) begin
        n_fail++;
        $display("FAIL reset_state: next/mode/steps = %b/%b/%0d, required 0/0/0",
                 bus.next_segment_re, bus.change_mode_re, bus.step_count);
      end
    end
  endtask

  task automatic test_manual_next();
    apply_reset();
    nq.push_back(2 + DB);
    for (int i = 0; i <= 12; i++) begin
      step();
      if (cyc == 0) bus.btn_next = 1'b1;
      pop_expect();
      n_cmp++;
      if ({bus.next_segment_re, bus.change_mode_re, bus.step_count} !== {en, em, es}) begin
        n_fail++;
        $display("FAIL manual_next c%0d: next/mode/steps = %b/%b/%0d, required %b/%b/%0d",
                 cyc, bus.next_segment_re, bus.change_mode_re, bus.step_count, en, em, es);
      end
      if (en) es++;
    end
  endtask

  task automatic test_mode_glitch();
    apply_reset();
    for (int i = 0; i <= 14; i++) begin
      step();
      if (cyc == 0) bus.btn_mode = 1'b1;
      if (cyc == 3) bus.btn_mode = 1'b0;
      pop_expect();
      n_cmp++;
      if ({bus.next_segment_re, bus.change_mode_re, bus.step_count} !== {en, em, es}) begin
        n_fail++;
        $display("FAIL mode_glitch c%0d: next/mode/steps = %b/%b/%0d, required %b/%b/%0d",
                 cyc, bus.next_segment_re, bus.change_mode_re, bus.step_count, en, em, es);
      end
      if (en) es++;
    end
  endtask

  task automatic test_auto();
    apply_reset();
    bus.auto_en = 1'b1;
    nq.push_back(AP - 1);
    nq.push_back(2 * AP - 1);
    for (int i = 0; i < 20; i++) begin
      step();
      pop_expect();
      n_cmp++;
      if ({bus.next_segment_re, bus.change_mode_re, bus.step_count} !== {en, em, es}) begin
        n_fail++;
        $display("FAIL auto_advance c%0d: next/mode/steps = %b/%b/%0d, required %b/%b/%0d",
                 cyc, bus.next_segment_re, bus.change_mode_re, bus.step_count, en, em, es);
      end
      if (en) es++;
    end
  endtask

  // The manual press at cycle 6 restarts the period: ticks follow at 14, 22.
  task automatic test_auto_restart();
    apply_reset();
    bus.auto_en = 1'b1;
    nq.push_back(2 + DB);
    nq.push_back(2 + DB + AP);
    nq.push_back(2 + DB + 2 * AP);
    for (int i = 0; i <= 25; i++) begin
      step();
      if (cyc == 0) bus.btn_next = 1'b1;
      pop_expect();
      n_cmp++;
      if ({bus.next_segment_re, bus.change_mode_re, bus.step_count} !== {en, em, es}) begin
        n_fail++;
        $display("FAIL auto_restart c%0d: next/mode/steps = %b/%b/%0d, required %b/%b/%0d",
                 cyc, bus.next_segment_re, bus.change_mode_re, bus.step_count, en, em, es);
      end
      if (en) es++;
    end
  endtask

  task automatic test_coincident_buttons();
    apply_reset();
    mq.push_back(2 + DB);
    nq.push_back(3 + DB);
    for (int i = 0; i <= 12; i++) begin
      step();
      if (cyc == 0) begin
        bus.btn_next = 1'b1;
        bus.btn_mode = 1'b1;
      end
      pop_expect();
      n_cmp++;
      if ({bus.next_segment_re, bus.change_mode_re, bus.step_count} !== {en, em, es}) begin
        n_fail++;
        $display("FAIL coincident_btn c%0d: next/mode/steps = %b/%b/%0d, required %b/%b/%0d",
                 cyc, bus.next_segment_re, bus.change_mode_re, bus.step_count, en, em, es);
      end
      if (en) es++;
    end
  endtask

  // Mode request lands on the auto tick: mode at 7, deferred next at 8.
  task automatic test_mode_over_auto();
    apply_reset();
    bus.auto_en = 1'b1;
    mq.push_back(AP - 1);
    nq.push_back(AP);
    nq.push_back(2 * AP - 1);
    for (int i = 0; i <= 17; i++) begin
      step();
      if (cyc == 1) bus.btn_mode = 1'b1;
      pop_expect();
      n_cmp++;
      if ({bus.next_segment_re, bus.change_mode_re, bus.step_count} !== {en, em, es}) begin
        n_fail++;
        $display("FAIL mode_over_auto c%0d: next/mode/steps = %b/%b/%0d, required %b/%b/%0d",
                 cyc, bus.next_segment_re, bus.change_mode_re, bus.step_count, en, em, es);
      end
      if (en) es++;
    end
  endtask

  task automatic test_reset_mid_press();
    apply_reset();
    nq.push_back(2 + DB);
    for (int i = 0; i <= 24; i++) begin
      step();
      if (cyc == 0)  bus.btn_next = 1'b1;
      if (cyc == 8)  bus.btn_next = 1'b0;
      if (cyc == 20) bus.btn_next = 1'b1;
      pop_expect();
      n_cmp++;
      if ({bus.next_segment_re, bus.change_mode_re, bus.step_count} !== {en, em, es}) begin
        n_fail++;
        $display("FAIL mid_press_pre c%0d: next/mode/steps = %b/%b/%0d, required %b/%b/%0d",
                 cyc, bus.next_segment_re, bus.change_mode_re, bus.step_count, en, em, es);
      end
      if (en) es++;
    end
    #2 async_reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.next_segment_re, bus.change_mode_re, bus.step_count} !== 10'd0) begin
      n_fail++;
      $display("FAIL mid_press_async: next/mode/steps = %b/%b/%0d, required 0/0/0",
               bus.next_segment_re, bus.change_mode_re, bus.step_count);
    end
    @(posedge clk);
    @(negedge clk);
    async_reset = 1'b0;
    cyc = -1;
    es  = '0;
    // Button is already high at the first edge after release.
    nq.push_back(1 + DB);
    for (int i = 0; i <= 9; i++) begin
      step();
      pop_expect();
      n_cmp++;
      if ({bus.next_segment_re, bus.change_mode_re, bus.step_count} !== {en, em, es}) begin
        n_fail++;
        $display("FAIL mid_press_post c%0d: next/mode/steps = %b/%b/%0d, required %b/%b/%0d",
                 cyc, bus.next_segment_re, bus.change_mode_re, bus.step_count, en, em, es);
      end
      if (en) es++;
    end
  endtask

  task automatic test_step_wrap();
    apply_reset();
    bus.auto_en = 1'b1;
    for (int k = 0; k < 256; k++) nq.push_back(int'(AP) - 1 + int'(AP) * k);
    for (int i = 0; i <= int'(AP) * 256 + 1; i++) begin
      step();
      pop_expect();
      n_cmp++;
      if ({bus.next_segment_re, bus.change_mode_re, bus.step_count} !== {en, em, es}) begin
        n_fail++;
        $display("FAIL step_wrap c%0d: next/mode/steps = %b/%b/%0d, required %b/%b/%0d",
                 cyc, bus.next_segment_re, bus.change_mode_re, bus.step_count, en, em, es);
      end
      if (en) es++;
    end
    n_cmp++;
    if (bus.step_count !== 8'd0) begin
      n_fail++;
      $display("FAIL step_wrap_final: step_count = %0d, required 0", bus.step_count);
    end
  endtask

  initial begin
    test_reset();
    test_manual_next();
    test_mode_glitch();
    test_auto();
    test_auto_restart();
    test_coincident_buttons();
    test_mode_over_auto();
    test_reset_mid_press();
    test_step_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
